// File: rtl/dm_byte_lane_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes, FSM states
// and the byte-lane enable decoder.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    // An all-zero mask marks a misaligned or illegal access.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
            SZ_WORD: lane_mask = (off == 2'b00) ? 4'b1111 : 4'b0000;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_lane_mem_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dm_byte_lane_mem_if;
    logic [31:0] pc;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        align_err;
    logic        busy;

    modport master (
        output pc, req_valid, req_we, req_size, req_unsigned, addr, wdata,
        input  rdata, rdata_valid, align_err, busy
    );

    modport slave (
        input  pc, req_valid, req_we, req_size, req_unsigned, addr, wdata,
        output rdata, rdata_valid, align_err, busy
    );
endinterface

// File: rtl/dm_byte_lane_mem_load_ext.sv
// Load lane select plus sign/zero extension of the addressed byte or halfword.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        w_half = '0;
        o_data = '0;
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_byte_lane_mem.sv
// MEM-stage data memory: byte-lane merged stores, extended loads, 0/1-cycle read latency,
// misalignment suppression and a post-reset clear engine that holds busy high.
module dm_byte_lane_mem
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 0,
    parameter int TRACE_EN     = 1
) (
    input  logic               clk,
    input  logic               reset,
    dm_byte_lane_mem_if.slave  dm_if
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    logic [31:0]   r_mem [DEPTH];
    state_e        r_state;
    state_e        w_state_nxt;
    logic [IW-1:0] r_cnt;
    logic          w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_CLEAR) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_cnt == IW'(DEPTH - 1)) w_state_nxt = ST_RUN;
            end
            default: w_busy = 1'b0;
        endcase
    end

    logic          w_accept;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    size_e         w_size;
    logic [3:0]    w_mask;
    logic          w_err;
    logic          w_store;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_wrep;
    logic [31:0]   w_merged;

    assign w_accept  = dm_if.req_valid & ~w_busy & ~reset;
    assign w_idx     = dm_if.addr[ADDR_WIDTH-1:2];
    assign w_off     = dm_if.addr[1:0];
    assign w_size    = size_e'(dm_if.req_size);
    assign w_mask    = lane_mask(w_size, w_off);
    assign w_err     = w_accept & (w_mask == 4'b0000);
    assign w_store   = w_accept & dm_if.req_we & (w_mask != 4'b0000);
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_wrep   = dm_if.wdata;
        w_merged = w_rd_word;
        case (w_size)
            SZ_BYTE: w_wrep = {4{dm_if.wdata[7:0]}};
            SZ_HALF: w_wrep = {2{dm_if.wdata[15:0]}};
            default: w_wrep = dm_if.wdata;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_mask[i]) w_merged[8*i +: 8] = w_wrep[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) r_mem[r_cnt] <= '0;
        else if (w_store)        r_mem[w_idx] <= w_merged;
    end

    logic [31:0] w_x_word;
    logic [1:0]  w_x_off;
    size_e       w_x_size;
    logic        w_x_uns;
    logic        w_x_valid;
    logic        w_x_err;
    logic [31:0] w_ext;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic [31:0] r_word;
            logic [1:0]  r_off;
            size_e       r_size;
            logic        r_uns;
            logic        r_valid;
            logic        r_err;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_word  <= '0;
                    r_off   <= '0;
                    r_size  <= SZ_BYTE;
                    r_uns   <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_word  <= w_rd_word;
                    r_off   <= w_off;
                    r_size  <= w_size;
                    r_uns   <= dm_if.req_unsigned;
                    r_valid <= w_accept & ~dm_if.req_we;
                    r_err   <= w_err;
                end
            end

            assign w_x_word  = r_word;
            assign w_x_off   = r_off;
            assign w_x_size  = r_size;
            assign w_x_uns   = r_uns;
            assign w_x_valid = r_valid;
            assign w_x_err   = r_err;
        end else begin : g_lat0
            assign w_x_word  = w_rd_word;
            assign w_x_off   = w_off;
            assign w_x_size  = w_size;
            assign w_x_uns   = dm_if.req_unsigned;
            assign w_x_valid = w_accept & ~dm_if.req_we;
            assign w_x_err   = w_err;
        end
    endgenerate

    dm_load_ext u_load_ext (
        .i_word     (w_x_word),
        .i_off      (w_x_off),
        .i_size     (w_x_size),
        .i_unsigned (w_x_uns),
        .o_data     (w_ext)
    );

    assign dm_if.rdata       = (w_x_valid & ~w_x_err) ? w_ext : '0;
    assign dm_if.rdata_valid = w_x_valid;
    assign dm_if.align_err   = w_x_err;
    assign dm_if.busy        = w_busy;

    generate
        if (TRACE_EN != 0) begin : g_trace
`ifndef SYNTHESIS
            always_ff @(posedge clk) begin
                if (w_store)
                    $display("%d@%h: *%h <= %h", $time, dm_if.pc, {dm_if.addr[31:2], 2'b00}, w_merged);
            end
`endif
        end
    endgenerate

    logic w_unused_bits;
    assign w_unused_bits = ^{dm_if.addr[31:ADDR_WIDTH], dm_if.pc};

endmodule
